// File: rtl/pipe_robot_if.sv
// Sensor and actuator bundle between the pipe robot's front-end and its controller.
// The controller takes the slave side; the sensor/actuator side takes the master side.
interface pipe_robot_if #(
    parameter int STEP_W = 8
);
    logic              follow_right;
    logic              head;
    logic              left;
    logic              right;
    logic              barrier;
    logic              under;
    logic              front;
    logic              turn;
    logic              turn_dir;
    logic              remove;
    logic              done;
    logic              fault;
    logic [STEP_W-1:0] steps;
    logic [STEP_W-1:0] trash;

    modport master (
        output follow_right, head, left, right, barrier, under,
        input  front, turn, turn_dir, remove, done, fault, steps, trash
    );

    modport slave (
        input  follow_right, head, left, right, barrier, under,
        output front, turn, turn_dir, remove, done, fault, steps, trash
    );
endinterface

// File: rtl/pipe_robot_ctrl.sv
// Wall-following controller for the pipe-cleaning robot: registered actions,
// bounded turn/remove retries with sticky fault, saturating step/trash counters.
module pipe_robot_ctrl #(
    parameter int MAX_TURNS  = 4,
    parameter int MAX_REMOVE = 3,
    parameter int STEP_W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    pipe_robot_if.slave  bus
);
    localparam int TW = $clog2(MAX_TURNS + 1);
    localparam int RW = $clog2(MAX_REMOVE + 1);
    localparam logic [TW-1:0] TURN_LIM   = TW'(MAX_TURNS);
    localparam logic [RW-1:0] REMOVE_LIM = RW'(MAX_REMOVE);

    typedef enum logic [2:0] {
        ST_RESET, ST_FIRST, ST_SEARCH, ST_ROTATE, ST_FOLLOW, ST_DONE, ST_FAULT
    } state_t;

    state_t            state, state_nxt, req_state;
    logic              mode_right, mode_nxt;
    logic [TW-1:0]     turn_cnt, turn_cnt_nxt;
    logic [RW-1:0]     remove_cnt, remove_cnt_nxt;
    logic              front_q, turn_q, dir_q, remove_q, done_q, fault_q;
    logic              front_nxt, turn_nxt, dir_nxt, remove_nxt, done_nxt, fault_nxt;
    logic [STEP_W-1:0] steps_q, trash_q, steps_nxt, trash_nxt;
    logic              wall, req_front, req_turn, req_dir;

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign wall = mode_right ? bus.right : bus.left;

    always_comb begin
        state_nxt      = state;
        mode_nxt       = mode_right;
        turn_cnt_nxt   = turn_cnt;
        remove_cnt_nxt = remove_cnt;
        front_nxt      = 1'b0;
        turn_nxt       = 1'b0;
        dir_nxt        = 1'b0;
        remove_nxt     = 1'b0;
        done_nxt       = done_q;
        fault_nxt      = fault_q;
        steps_nxt      = steps_q;
        trash_nxt      = trash_q;
        req_front      = 1'b0;
        req_turn       = 1'b0;
        req_dir        = 1'b0;
        req_state      = state;

        // Wall-following rule for the current state, before priorities and bounds
        case (state)
            ST_FIRST, ST_ROTATE: begin
                if (wall && !bus.head) begin
                    req_front = 1'b1;
                    req_state = ST_SEARCH;
                end else begin
                    req_turn = 1'b1;
                end
            end
            ST_SEARCH: begin
                if (wall && !bus.head) begin
                    req_front = 1'b1;
                end else if (wall) begin
                    req_turn  = 1'b1;
                    req_state = ST_ROTATE;
                end else begin
                    req_turn  = 1'b1;
                    req_dir   = 1'b1;
                    req_state = ST_FOLLOW;
                end
            end
            ST_FOLLOW: begin
                req_turn  = bus.head;
                req_front = !bus.head;
                req_state = bus.head ? ST_ROTATE : ST_SEARCH;
            end
            default: ;
        endcase

        case (state)
            ST_RESET: begin
                mode_nxt  = bus.follow_right;
                state_nxt = ST_FIRST;
            end
            ST_FIRST, ST_SEARCH, ST_ROTATE, ST_FOLLOW: begin
                if (bus.under) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else if (bus.head && bus.barrier) begin
                    state_nxt = ST_FAULT;
                    fault_nxt = 1'b1;
                end else if (bus.barrier) begin
                    if (remove_cnt == REMOVE_LIM) begin
                        state_nxt = ST_FAULT;
                        fault_nxt = 1'b1;
                    end else begin
                        remove_nxt     = 1'b1;
                        remove_cnt_nxt = remove_cnt + 1'b1;
                        turn_cnt_nxt   = '0;
                        // A new episode starts only when the previous cycle was not removing
                        if (!remove_q) trash_nxt = sat_inc(trash_q);
                    end
                end else begin
                    remove_cnt_nxt = '0;
                    if (req_front) begin
                        front_nxt    = 1'b1;
                        turn_cnt_nxt = '0;
                        steps_nxt    = sat_inc(steps_q);
                        state_nxt    = req_state;
                    end else if (req_turn && turn_cnt == TURN_LIM) begin
                        state_nxt = ST_FAULT;
                        fault_nxt = 1'b1;
                    end else if (req_turn) begin
                        turn_nxt     = 1'b1;
                        dir_nxt      = req_dir;
                        turn_cnt_nxt = turn_cnt + 1'b1;
                        state_nxt    = req_state;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_RESET;
            mode_right <= 1'b0;
            turn_cnt   <= '0;
            remove_cnt <= '0;
            front_q    <= 1'b0;
            turn_q     <= 1'b0;
            dir_q      <= 1'b0;
            remove_q   <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            steps_q    <= '0;
            trash_q    <= '0;
        end else begin
            state      <= state_nxt;
            mode_right <= mode_nxt;
            turn_cnt   <= turn_cnt_nxt;
            remove_cnt <= remove_cnt_nxt;
            front_q    <= front_nxt;
            turn_q     <= turn_nxt;
            dir_q      <= dir_nxt;
            remove_q   <= remove_nxt;
            done_q     <= done_nxt;
            fault_q    <= fault_nxt;
            steps_q    <= steps_nxt;
            trash_q    <= trash_nxt;
        end
    end

    assign bus.front    = front_q;
    assign bus.turn     = turn_q;
    assign bus.turn_dir = dir_q;
    assign bus.remove   = remove_q;
    assign bus.done     = done_q;
    assign bus.fault    = fault_q;
    assign bus.steps    = steps_q;
    assign bus.trash    = trash_q;
endmodule

// File: tb/tb_pipe_robot_ctrl.sv
// Bench for pipe_robot_ctrl: directed scenarios plus randomized sensor traffic
// compared every cycle against a behavioural model of the controller's rules.
module tb_pipe_robot_ctrl;
    localparam int MT   = 4;
    localparam int MR   = 3;
    localparam int SMAX = 255;

    // Model phases (own numbering, independent of the design)
    localparam int P_IDLE = 10, P_FIRST = 11, P_SEARCH = 12, P_ROTATE = 13;
    localparam int P_FOLLOW = 14, P_DONE = 15, P_FAULT = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pipe_robot_if #(.STEP_W(8)) bus ();

    pipe_robot_ctrl #(.MAX_TURNS(MT), .MAX_REMOVE(MR), .STEP_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int m_phase, m_turns, m_removes, m_steps, m_trash;
    bit m_right, m_front, m_turn, m_dir, m_remove, m_done, m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_turns = 0; m_removes = 0; m_steps = 0; m_trash = 0;
        m_right = 0; m_front = 0; m_turn = 0; m_dir = 0; m_remove = 0;
        m_done = 0; m_fault = 0;
    endtask

    task automatic model_edge();
        bit s, was_remove, want_front, want_dir;
        int goal;
        s          = m_right ? bus.right : bus.left;
        was_remove = m_remove;
        m_front = 0; m_turn = 0; m_dir = 0; m_remove = 0;
        if (m_phase == P_IDLE) begin
            m_right = bus.follow_right;
            m_phase = P_FIRST;
            return;
        end
        if (m_phase == P_DONE || m_phase == P_FAULT) return;
        want_front = 0; want_dir = 0; goal = m_phase;
        if (m_phase == P_FOLLOW) begin
            want_front = !bus.head;
            goal = bus.head ? P_ROTATE : P_SEARCH;
        end else if (s && !bus.head) begin
            want_front = 1;
            goal = P_SEARCH;
        end else if (m_phase == P_SEARCH) begin
            want_dir = !s;
            goal = s ? P_ROTATE : P_FOLLOW;
        end
        if (bus.under) begin
            m_phase = P_DONE; m_done = 1;
        end else if (bus.head && bus.barrier) begin
            m_phase = P_FAULT; m_fault = 1;
        end else if (bus.barrier) begin
            if (m_removes >= MR) begin
                m_phase = P_FAULT; m_fault = 1;
            end else begin
                m_remove = 1; m_removes++; m_turns = 0;
                if (!was_remove && m_trash < SMAX) m_trash++;
            end
        end else begin
            m_removes = 0;
            if (want_front) begin
                m_front = 1; m_turns = 0; m_phase = goal;
                if (m_steps < SMAX) m_steps++;
            end else if (m_turns >= MT) begin
                m_phase = P_FAULT; m_fault = 1;
            end else begin
                m_turn = 1; m_dir = want_dir; m_turns++; m_phase = goal;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".front"},  32'(bus.front),  32'(m_front));
        chk({tag, ".turn"},   32'(bus.turn),   32'(m_turn));
        if (m_turn) chk({tag, ".turn_dir"}, 32'(bus.turn_dir), 32'(m_dir));
        chk({tag, ".remove"}, 32'(bus.remove), 32'(m_remove));
        chk({tag, ".done"},   32'(bus.done),   32'(m_done));
        chk({tag, ".fault"},  32'(bus.fault),  32'(m_fault));
        chk({tag, ".steps"},  32'(bus.steps),  32'(m_steps));
        chk({tag, ".trash"},  32'(bus.trash),  32'(m_trash));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic set_in(input bit l, input bit r, input bit h, input bit b, input bit u);
        bus.left = l; bus.right = r; bus.head = h; bus.barrier = b; bus.under = u;
    endtask

    task automatic do_reset(input bit fr);
        @(negedge clock);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        bus.follow_right = fr;
        model_reset();
        #2;
        chk("rst.outputs", {26'd0, bus.front, bus.turn, bus.turn_dir, bus.remove, bus.done, bus.fault}, 32'd0);
        chk("rst.steps", 32'(bus.steps), 32'd0);
        chk("rst.trash", 32'(bus.trash), 32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        bus.follow_right = 1'b0;
        set_in(0, 0, 0, 0, 0);

        // Left wall straight run
        do_reset(0);
        bus.left = 1;
        tick("run.e1");
        chk("run.e1_front", 32'(bus.front), 32'd0);
        for (int i = 2; i <= 6; i++) begin
            tick("run");
            chk("run.front", 32'(bus.front), 32'd1);
        end
        chk("run.steps5", 32'(bus.steps), 32'd5);

        // Two-cycle trash episode in SEARCH
        bus.barrier = 1;
        tick("rem"); chk("rem.r1", 32'(bus.remove), 32'd1);
        tick("rem"); chk("rem.r2", 32'(bus.remove), 32'd1);
        bus.barrier = 0;
        tick("rem"); chk("rem.front", 32'(bus.front), 32'd1);
        chk("rem.trash1", 32'(bus.trash), 32'd1);

        // Stuck trash
        do_reset(0);
        bus.left = 1;
        tick("stk"); tick("stk");
        bus.barrier = 1;
        for (int i = 0; i < MR; i++) begin
            tick("stk"); chk("stk.remove", 32'(bus.remove), 32'd1);
        end
        tick("stk"); chk("stk.fault", 32'(bus.fault), 32'd1);
        chk("stk.quiet", {29'd0, bus.front, bus.turn, bus.remove}, 32'd0);
        bus.barrier = 0;
        tick("stk"); tick("stk"); chk("stk.hold", 32'(bus.fault), 32'd1);

        // Trapped in FIRST
        do_reset(0);
        tick("trp");
        for (int i = 0; i < MT; i++) begin
            tick("trp");
            chk("trp.turn", {30'd0, bus.turn, bus.turn_dir}, 32'd2);
        end
        tick("trp"); chk("trp.fault", 32'(bus.fault), 32'd1);

        // Right mode: SEARCH -> ROTATE -> forward
        do_reset(1);
        bus.right = 1;
        tick("rgt"); tick("rgt");
        bus.head = 1;
        tick("rgt"); chk("rgt.turn", {30'd0, bus.turn, bus.turn_dir}, 32'd2);
        bus.head = 0;
        tick("rgt"); chk("rgt.front", 32'(bus.front), 32'd1);

        // Exit during FOLLOW wins over trash, then reset out of DONE
        do_reset(0);
        bus.left = 1;
        tick("ext"); tick("ext");
        bus.left = 0;
        tick("ext"); chk("ext.toward", {30'd0, bus.turn, bus.turn_dir}, 32'd3);
        bus.under = 1; bus.barrier = 1;
        tick("ext"); chk("ext.done", 32'(bus.done), 32'd1);
        chk("ext.quiet", {29'd0, bus.front, bus.turn, bus.remove}, 32'd0);
        do_reset(0);

        // Counter saturation: alternating trash and forward moves
        bus.left = 1;
        tick("sat");
        for (int i = 0; i < 600; i++) begin
            bus.barrier = i[0] ? 1'b0 : 1'b1;
            tick("sat");
        end
        chk("sat.steps", 32'(bus.steps), 32'd255);
        chk("sat.trash", 32'(bus.trash), 32'd255);

        // Randomized traffic
        do_reset(1'($urandom_range(0, 1)));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset(1'($urandom_range(0, 1)));
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 49) == 0);
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
